// File: rtl/riscv_pkg.sv
// Shared definitions for the front-end pipeline.
// Holds the architectural widths, the default instruction-queue depth and the
// entry layout the queue stores for each fetched instruction.
package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int INST_W   = 32;
    localparam int IQ_DEPTH = 8;

    // One buffered fetch result: where it came from and what was read.
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode.
// Fetch pushes (pc, instruction) pairs; decode pops them in program order with
// a ready/valid handshake. flush_in empties the queue in one cycle on redirect.
// The head entry is shown ahead combinationally; nothing from storage is ever
// exposed while the queue is empty.
//
// Ports:
//   clk_in        rising-edge clock
//   rst_in        synchronous active-high reset, overrides rdy_in
//   rdy_in        global ready; when low, no state changes
//   flush_in      drop every buffered entry (gated by rdy_in)
//   if_valid_in   fetch offers an entry
//   if_pc_in      pc of the offered entry
//   if_inst_in    instruction word of the offered entry
//   if_ready_out  queue can accept a push (not full)
//   iq_valid_out  head entry valid (not empty)
//   iq_pc_out     head pc, 0 when empty
//   iq_inst_out   head instruction, 0 when empty
//   dec_ready_in  decode consumes the head this cycle
//   count_out     number of occupied entries, 0..DEPTH
module inst_queue
    import riscv_pkg::*;
#(
    parameter  int DEPTH = IQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              if_valid_in,
    input  logic [XLEN-1:0]   if_pc_in,
    input  logic [INST_W-1:0] if_inst_in,
    output logic              if_ready_out,
    output logic              iq_valid_out,
    output logic [XLEN-1:0]   iq_pc_out,
    output logic [INST_W-1:0] iq_inst_out,
    input  logic              dec_ready_in,
    output logic [PTR_W:0]    count_out
);

    // Pointers carry an extra wrap bit above the index so that full and
    // empty can be told apart without a separate occupancy counter.
    logic [PTR_W:0] head_q, head_d;
    logic [PTR_W:0] tail_q, tail_d;

    // Entry storage has no reset so it can map onto distributed RAM.
    iq_entry_t mem_q [DEPTH];

    logic      empty;
    logic      full;
    logic      pushFire;
    logic      popFire;
    iq_entry_t headEntry;

    assign empty = (head_q == tail_q);
    assign full  = (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]) &&
                   (head_q[PTR_W] != tail_q[PTR_W]);

    // if_ready_out depends only on registered state, so a pop in the same
    // cycle never frees a slot for a push into a full queue.
    assign if_ready_out = !full;
    assign iq_valid_out = !empty;

    assign pushFire = rdy_in && if_valid_in && !full  && !flush_in;
    assign popFire  = rdy_in && dec_ready_in && !empty && !flush_in;

    // Show-ahead read of the head slot, masked to zero while empty so stale
    // storage left behind by a flush is never visible to decode.
    assign headEntry   = mem_q[head_q[PTR_W-1:0]];
    assign iq_pc_out   = empty ? '0 : headEntry.pc;
    assign iq_inst_out = empty ? '0 : headEntry.inst;

    // Modulo 2*DEPTH subtraction falls out of the PTR_W+1 bit width.
    assign count_out = tail_q - head_q;

    // Next-state pointer logic: a flush (only while rdy_in is high) wins over
    // any push or pop offered in the same cycle.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (rdy_in && flush_in) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (pushFire) begin
                tail_d = tail_q + (PTR_W+1)'(1);
            end
            if (popFire) begin
                head_d = head_q + (PTR_W+1)'(1);
            end
        end
    end

    // Pointer registers; reset overrides everything including rdy_in low.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Storage write on an accepted push only.
    always_ff @(posedge clk_in) begin
        if (pushFire && !rst_in) begin
            mem_q[tail_q[PTR_W-1:0]] <= '{pc: if_pc_in, inst: if_inst_in};
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: a reference queue of expected entries
// is filled when a push is offered and drained when a pop is offered, and
// each scenario task compares DUT outputs against it.
module tb_inst_queue;
    import riscv_pkg::*;

    localparam int DEPTH = 8;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        if_valid_in;
    logic [31:0] if_pc_in;
    logic [31:0] if_inst_in;
    logic        if_ready_out;
    logic        iq_valid_out;
    logic [31:0] iq_pc_out;
    logic [31:0] iq_inst_out;
    logic        dec_ready_in;
    logic [3:0]  count_out;

    int total = 0;
    int bad   = 0;

    iq_entry_t sb[$];

    always #5 clk_in = ~clk_in;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .flush_in     (flush_in),
        .if_valid_in  (if_valid_in),
        .if_pc_in     (if_pc_in),
        .if_inst_in   (if_inst_in),
        .if_ready_out (if_ready_out),
        .iq_valid_out (iq_valid_out),
        .iq_pc_out    (iq_pc_out),
        .iq_inst_out  (iq_inst_out),
        .dec_ready_in (dec_ready_in),
        .count_out    (count_out)
    );

    // One clock of stimulus, entered and left at posedge+1. The head seen
    // by the DUT is sampled mid-cycle; the reference queue decides which
    // handshakes fire from its own occupancy.
    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic pop, input logic flush, input logic rdy,
                         output logic popFired, output iq_entry_t expHead,
                         output logic [31:0] gotPc, output logic [31:0] gotInst);
        logic pushOk;
        if_valid_in  = v;
        if_pc_in     = pc;
        if_inst_in   = inst;
        dec_ready_in = pop;
        flush_in     = flush;
        rdy_in       = rdy;
        #4;
        gotPc    = iq_pc_out;
        gotInst  = iq_inst_out;
        pushOk   = rdy && v && !flush && (sb.size() < DEPTH);
        popFired = rdy && pop && !flush && (sb.size() > 0);
        expHead  = '0;
        if (popFired) begin
            expHead = sb[0];
            void'(sb.pop_front());
        end
        if (rdy && flush) sb.delete();
        if (pushOk) sb.push_back('{pc: pc, inst: inst});
        @(posedge clk_in);
        #1;
        if_valid_in  = 1'b0;
        dec_ready_in = 1'b0;
        flush_in     = 1'b0;
        rdy_in       = 1'b1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        sb.delete();
        total++; if (if_ready_out !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%0b want=1", if_ready_out); end
        total++; if (iq_valid_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0b want=0", iq_valid_out); end
        total++; if (iq_pc_out !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc got=%h want=0", iq_pc_out); end
        total++; if (iq_inst_out !== 32'h0) begin bad++; $display("[TB] FAIL reset_inst got=%h want=0", iq_inst_out); end
        total++; if (count_out !== 4'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", count_out); end
    endtask

    task automatic test_basic();
        logic [31:0] insts [3];
        logic pf; iq_entry_t e; logic [31:0] gp, gi;
        insts[0] = 32'h00000013; insts[1] = 32'h00100093; insts[2] = 32'h00200113;
        for (int i = 0; i < 3; i++) drive(1'b1, 32'(4*i), insts[i], 1'b0, 1'b0, 1'b1, pf, e, gp, gi);
        total++; if (count_out !== 4'd3) begin bad++; $display("[TB] FAIL basic_count got=%0d want=3", count_out); end
        total++; if (iq_pc_out !== 32'h0) begin bad++; $display("[TB] FAIL basic_head got=%h want=0", iq_pc_out); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, pf, e, gp, gi);
            total++; if (gp !== 32'(4*i) || gi !== insts[i] || gp !== e.pc || gi !== e.inst)
                begin bad++; $display("[TB] FAIL basic_pop%0d got=%h/%h want=%h/%h", i, gp, gi, 32'(4*i), insts[i]); end
        end
        total++; if (iq_valid_out !== 1'b0) begin bad++; $display("[TB] FAIL basic_empty got=%0b want=0", iq_valid_out); end
    endtask

    task automatic test_full();
        logic pf; iq_entry_t e; logic [31:0] gp, gi;
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 32'h200 + 32'(4*i), 32'hA000 + 32'(i), 1'b0, 1'b0, 1'b1, pf, e, gp, gi);
        total++; if (if_ready_out !== 1'b0) begin bad++; $display("[TB] FAIL full_ready got=%0b want=0", if_ready_out); end
        total++; if (count_out !== 4'd8) begin bad++; $display("[TB] FAIL full_count got=%0d want=8", count_out); end
        drive(1'b1, 32'h999, 32'h999, 1'b0, 1'b0, 1'b1, pf, e, gp, gi);
        total++; if (count_out !== 4'd8) begin bad++; $display("[TB] FAIL full_ninth got=%0d want=8", count_out); end
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, pf, e, gp, gi);
        total++; if (gp !== 32'h200) begin bad++; $display("[TB] FAIL full_pop got=%h want=200", gp); end
        total++; if (if_ready_out !== 1'b1 || count_out !== 4'd7)
            begin bad++; $display("[TB] FAIL full_after_pop got=%0b/%0d want=1/7", if_ready_out, count_out); end
        for (int i = 1; i < DEPTH; i++) begin
            drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, pf, e, gp, gi);
            total++; if (!pf || gp !== e.pc || gi !== e.inst || gp !== 32'h200 + 32'(4*i))
                begin bad++; $display("[TB] FAIL full_drain%0d got=%h want=%h", i, gp, 32'h200 + 32'(4*i)); end
        end
        total++; if (iq_valid_out !== 1'b0) begin bad++; $display("[TB] FAIL full_empty got=%0b want=0", iq_valid_out); end
    endtask

    task automatic test_stream();
        logic pf; iq_entry_t e; logic [31:0] gp, gi;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h1000 + 32'(4*i), 32'h5000 + 32'(i), 1'b1, 1'b0, 1'b1, pf, e, gp, gi);
            total++; if (count_out !== 4'd1) begin bad++; $display("[TB] FAIL stream_count%0d got=%0d want=1", i, count_out); end
            if (i > 0) begin
                total++; if (gp !== 32'h1000 + 32'(4*(i-1)) || gi !== e.inst)
                    begin bad++; $display("[TB] FAIL stream_pc%0d got=%h want=%h", i, gp, 32'h1000 + 32'(4*(i-1))); end
            end
        end
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, pf, e, gp, gi);
        total++; if (gp !== 32'h104C || iq_valid_out !== 1'b0)
            begin bad++; $display("[TB] FAIL stream_last got=%h/%0b want=104c/0", gp, iq_valid_out); end
    endtask

    task automatic test_flush();
        logic pf; iq_entry_t e; logic [31:0] gp, gi;
        for (int i = 0; i < 5; i++) drive(1'b1, 32'h400 + 32'(4*i), 32'h77, 1'b0, 1'b0, 1'b1, pf, e, gp, gi);
        drive(1'b1, 32'h4FC, 32'h88, 1'b1, 1'b1, 1'b1, pf, e, gp, gi);
        total++; if (count_out !== 4'd0 || iq_valid_out !== 1'b0 || if_ready_out !== 1'b1)
            begin bad++; $display("[TB] FAIL flush_state got=%0d/%0b/%0b want=0/0/1", count_out, iq_valid_out, if_ready_out); end
        drive(1'b1, 32'h100, 32'h13, 1'b0, 1'b0, 1'b1, pf, e, gp, gi);
        total++; if (iq_valid_out !== 1'b1 || iq_pc_out !== 32'h100 || count_out !== 4'd1)
            begin bad++; $display("[TB] FAIL flush_repush got=%0b/%h/%0d want=1/100/1", iq_valid_out, iq_pc_out, count_out); end
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, pf, e, gp, gi);
        total++; if (gp !== 32'h100 || iq_valid_out !== 1'b0)
            begin bad++; $display("[TB] FAIL flush_pop got=%h/%0b want=100/0", gp, iq_valid_out); end
    endtask

    task automatic test_rdy_low();
        logic pf; iq_entry_t e; logic [31:0] gp, gi;
        drive(1'b1, 32'h300, 32'h31, 1'b0, 1'b0, 1'b1, pf, e, gp, gi);
        drive(1'b1, 32'h304, 32'h32, 1'b0, 1'b0, 1'b1, pf, e, gp, gi);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h308, 32'h33, 1'b1, (i >= 2), 1'b0, pf, e, gp, gi);
            total++; if (count_out !== 4'd2 || iq_pc_out !== 32'h300 || iq_inst_out !== 32'h31 ||
                         iq_valid_out !== 1'b1 || if_ready_out !== 1'b1)
                begin bad++; $display("[TB] FAIL stall%0d got=%0d/%h/%h want=2/300/31", i, count_out, iq_pc_out, iq_inst_out); end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, pf, e, gp, gi);
            total++; if (gp !== 32'h300 + 32'(4*i) || gi !== e.inst)
                begin bad++; $display("[TB] FAIL stall_drain%0d got=%h want=%h", i, gp, 32'h300 + 32'(4*i)); end
        end
    endtask

    task automatic test_reset_stall();
        logic pf; iq_entry_t e; logic [31:0] gp, gi;
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 32'h600 + 32'(4*i), 32'h66, 1'b0, 1'b0, 1'b1, pf, e, gp, gi);
        total++; if (count_out !== 4'd8) begin bad++; $display("[TB] FAIL rststall_fill got=%0d want=8", count_out); end
        rdy_in = 1'b0;
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        rdy_in = 1'b1;
        sb.delete();
        total++; if (if_ready_out !== 1'b1 || iq_valid_out !== 1'b0 || iq_pc_out !== 32'h0 ||
                     iq_inst_out !== 32'h0 || count_out !== 4'd0)
            begin bad++; $display("[TB] FAIL rststall got=%0b/%0b/%h/%h/%0d want=1/0/0/0/0",
                                  if_ready_out, iq_valid_out, iq_pc_out, iq_inst_out, count_out); end
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; if_valid_in = 1'b0;
        if_pc_in = '0; if_inst_in = '0; dec_ready_in = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_full();
        test_stream();
        test_flush();
        test_rdy_low();
        test_reset_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
